// File: rtl/aha_sif_pkg.sv
// Shared widths, FIFO entry layout and output FSM encoding for the SIF write serializer.
package aha_sif_pkg;

  localparam int unsigned SIF_ADDR_W = 32;
  localparam int unsigned SIF_DATA_W = 64;
  localparam int unsigned SIF_STRB_W = 8;
  localparam int unsigned CFG_DATA_W = 32;
  localparam int unsigned CFG_STRB_W = 4;

  // Beats are 8-byte aligned, so only address bits [31:3] are buffered.
  localparam int unsigned ENTRY_ADDR_W = SIF_ADDR_W - 3;
  localparam int unsigned ENTRY_W      = ENTRY_ADDR_W + SIF_STRB_W + SIF_DATA_W;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSendLo = 2'b01,
    StSendHi = 2'b10
  } state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [SIF_STRB_W-1:0]   strb;
    logic [SIF_DATA_W-1:0]   data;
  } entry_t;

  function automatic logic has_lo(input logic [SIF_STRB_W-1:0] strb);
    return |strb[CFG_STRB_W-1:0];
  endfunction

  function automatic logic has_hi(input logic [SIF_STRB_W-1:0] strb);
    return |strb[SIF_STRB_W-1:CFG_STRB_W];
  endfunction

  // Word address of the low (hi=0) or high (hi=1) half of a buffered beat.
  function automatic logic [SIF_ADDR_W-1:0] word_addr(input logic [ENTRY_ADDR_W-1:0] addr,
                                                       input logic                    hi);
    return {addr, hi, 2'b00};
  endfunction

endpackage

// File: rtl/aha_sif_wr_serializer_if.sv
// SIF write-beat input, CFG word-write output and status signals of the serializer.
interface aha_sif_wr_serializer_if;
  import aha_sif_pkg::*;

  logic [SIF_ADDR_W-1:0] SIF_ADDR;
  logic [SIF_STRB_W-1:0] SIF_STRB;
  logic                  SIF_WE;
  logic [SIF_DATA_W-1:0] SIF_DATA;

  logic [SIF_ADDR_W-1:0] CFG_ADDR;
  logic [CFG_DATA_W-1:0] CFG_DATA;
  logic [CFG_STRB_W-1:0] CFG_STRB;
  logic                  CFG_VALID;
  logic                  CFG_READY;

  logic                  FULL;
  logic                  OVERFLOW;
  logic                  OVF_CLR;

  // Upstream beat source and CFG sink, as seen from outside the serializer.
  modport master (
    output SIF_ADDR, SIF_STRB, SIF_WE, SIF_DATA, CFG_READY, OVF_CLR,
    input  CFG_ADDR, CFG_DATA, CFG_STRB, CFG_VALID, FULL, OVERFLOW
  );

  modport slave (
    input  SIF_ADDR, SIF_STRB, SIF_WE, SIF_DATA, CFG_READY, OVF_CLR,
    output CFG_ADDR, CFG_DATA, CFG_STRB, CFG_VALID, FULL, OVERFLOW
  );

endinterface

// File: rtl/aha_sif_sync_fifo.sv
// Synchronous FIFO with head data visible combinationally; Depth must be a power of two.
module aha_sif_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Pointers wrap naturally because Depth is a power of two.
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aha_sif_wr_serializer.sv
// Buffers 64-bit SIF write beats and replays them as 0, 1 or 2 handshaked 32-bit CFG writes.
module aha_sif_wr_serializer
  import aha_sif_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                    ACLK,
  input logic                    ARESET,
  aha_sif_wr_serializer_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  entry_t               wr_entry;
  entry_t               head_entry;
  entry_t               hold_q, hold_d;
  state_e               state_q, state_d;
  logic                 ovf_q, ovf_d;
  logic [ENTRY_W-1:0]   head_bits;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop;
  logic                 can_push;
  logic                 load;
  logic                 unused_addr_lsb;

  assign wr_entry        = '{addr: bus.SIF_ADDR[SIF_ADDR_W-1:3],
                             strb: bus.SIF_STRB,
                             data: bus.SIF_DATA};
  assign unused_addr_lsb = ^bus.SIF_ADDR[2:0];
  assign head_entry      = entry_t'(head_bits);

  // Space is judged on the registered count, so a same-cycle pop never admits a push.
  assign can_push  = (fifo_count < CntW'(FIFO_DEPTH));
  assign fifo_push = bus.SIF_WE && can_push;

  aha_sif_sync_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_entry),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (bus.OVF_CLR)              ovf_d = 1'b0;
    if (bus.SIF_WE && !can_push)  ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    load     = 1'b0;

    case (state_q)
      StIdle: begin
        load = !fifo_empty;
      end
      StSendLo: begin
        if (bus.CFG_READY) begin
          if (has_hi(hold_q.strb)) begin
            state_d = StSendHi;
          end else begin
            state_d = StIdle;
            load    = !fifo_empty;
          end
        end
      end
      StSendHi: begin
        if (bus.CFG_READY) begin
          state_d = StIdle;
          load    = !fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading on the finishing handshake keeps words back-to-back across entries.
    if (load) begin
      fifo_pop = 1'b1;
      hold_d   = head_entry;
      if (has_lo(head_entry.strb)) begin
        state_d = StSendLo;
      end else if (has_hi(head_entry.strb)) begin
        state_d = StSendHi;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    bus.CFG_VALID = 1'b0;
    bus.CFG_ADDR  = '0;
    bus.CFG_DATA  = '0;
    bus.CFG_STRB  = '0;
    case (state_q)
      StSendLo: begin
        bus.CFG_VALID = 1'b1;
        bus.CFG_ADDR  = word_addr(hold_q.addr, 1'b0);
        bus.CFG_DATA  = hold_q.data[CFG_DATA_W-1:0];
        bus.CFG_STRB  = hold_q.strb[CFG_STRB_W-1:0];
      end
      StSendHi: begin
        bus.CFG_VALID = 1'b1;
        bus.CFG_ADDR  = word_addr(hold_q.addr, 1'b1);
        bus.CFG_DATA  = hold_q.data[SIF_DATA_W-1:CFG_DATA_W];
        bus.CFG_STRB  = hold_q.strb[SIF_STRB_W-1:CFG_STRB_W];
      end
      default: ;
    endcase
  end

  assign bus.FULL     = fifo_full;
  assign bus.OVERFLOW = ovf_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_aha_sif_wr_serializer.sv
// Scoreboard bench: a word-level reference model predicts CFG writes, FULL, OVERFLOW and VALID.
module tb_aha_sif_wr_serializer;
  import aha_sif_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  word_t       exp_q[$];
  int unsigned hs_cyc_q[$];

  // Reference model state: word counts of beats in the FIFO, words left in hold, sticky flag.
  int unsigned model_q[$];
  int unsigned words_m = 0;
  bit          ovf_m = 1'b0;

  aha_sif_wr_serializer_if bus ();

  aha_sif_wr_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int unsigned nwords(input logic [7:0] s);
    int unsigned n;
    n = 0;
    if (s[3:0] != 4'h0) n++;
    if (s[7:4] != 4'h0) n++;
    return n;
  endfunction

  // Reference model, evaluated mid-cycle on the inputs that the next edge will sample.
  initial forever begin
    bit          full_now;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    @(negedge clk);
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      words_m = 0;
      ovf_m   = 1'b0;
    end else begin
      chk("valid", 64'(bus.CFG_VALID), 64'(words_m != 0));
      chk("full", 64'(bus.FULL), 64'(model_q.size() == DEPTH));
      chk("overflow", 64'(bus.OVERFLOW), 64'(ovf_m));
      full_now = (model_q.size() == DEPTH);
      if (words_m != 0 && bus.CFG_READY) words_m--;
      if (words_m == 0 && model_q.size() != 0) words_m = model_q.pop_front();
      if (bus.OVF_CLR) ovf_m = 1'b0;
      if (bus.SIF_WE) begin
        if (full_now) begin
          ovf_m = 1'b1;
        end else begin
          a = bus.SIF_ADDR;
          d = bus.SIF_DATA;
          s = bus.SIF_STRB;
          model_q.push_back(nwords(s));
          if (s[3:0] != 4'h0)
            exp_q.push_back('{addr: a & 32'hFFFF_FFF8, data: d[31:0], strb: s[3:0]});
          if (s[7:4] != 4'h0)
            exp_q.push_back('{addr: (a & 32'hFFFF_FFF8) + 32'd4, data: d[63:32], strb: s[7:4]});
        end
      end
    end
  end

  // Monitor: compares each handshake against the scoreboard and checks stability under stall.
  initial begin
    word_t prev, cur, e;
    bit    stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = '{addr: bus.CFG_ADDR, data: bus.CFG_DATA, strb: bus.CFG_STRB};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(bus.CFG_VALID), 64'(1));
          chk("stall_addr", 64'(cur.addr), 64'(prev.addr));
          chk("stall_data", 64'(cur.data), 64'(prev.data));
          chk("stall_strb", 64'(cur.strb), 64'(prev.strb));
        end
        if (bus.CFG_VALID && bus.CFG_READY) begin
          hs_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write",
                     cur.addr, cur.data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(cur.addr), 64'(e.addr));
            chk("wr_data", 64'(cur.data), 64'(e.data));
            chk("wr_strb", 64'(cur.strb), 64'(e.strb));
          end
        end
        stall = bus.CFG_VALID && !bus.CFG_READY;
        prev  = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
    bus.SIF_ADDR = a;
    bus.SIF_STRB = s;
    bus.SIF_DATA = d;
    bus.SIF_WE   = 1'b1;
    tick();
    bus.SIF_WE   = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || bus.CFG_VALID) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int unsigned n;
    int unsigned sent;
    int unsigned guard;
    bus.SIF_ADDR  = '0;
    bus.SIF_STRB  = '0;
    bus.SIF_DATA  = '0;
    bus.SIF_WE    = 1'b0;
    bus.CFG_READY = 1'b0;
    bus.OVF_CLR   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", 64'(bus.CFG_VALID), 64'(0));
    chk("rst_addr", 64'(bus.CFG_ADDR), 64'(0));
    chk("rst_data", 64'(bus.CFG_DATA), 64'(0));
    chk("rst_strb", 64'(bus.CFG_STRB), 64'(0));
    chk("rst_full", 64'(bus.FULL), 64'(0));
    chk("rst_overflow", 64'(bus.OVERFLOW), 64'(0));

    // Full strobe: two words at N+2 and N+3.
    bus.CFG_READY = 1'b1;
    hs_cyc_q.delete();
    n = cyc;
    beat(32'h1000_0008, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD);
    drain(20);
    chk("full_strb_writes", 64'(hs_cyc_q.size()), 64'(2));
    chk("lat_first", 64'(hs_cyc_q[0]), 64'(n + 2));
    chk("lat_second", 64'(hs_cyc_q[1]), 64'(n + 3));

    // Partial strobes: one word each.
    hs_cyc_q.delete();
    beat(32'h2000_0010, 8'hF0, 64'h1111_2222_3333_4444);
    beat(32'h2000_0018, 8'h03, 64'h5555_6666_7777_8888);
    drain(20);
    chk("partial_writes", 64'(hs_cyc_q.size()), 64'(2));

    // An all-zero beat between two single-word beats adds exactly one cycle of gap.
    hs_cyc_q.delete();
    beat(32'h2100_0000, 8'h0F, 64'h0123_4567_89AB_CDEF);
    beat(32'h2100_0008, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    beat(32'h2100_0010, 8'h0F, 64'hFEDC_BA98_7654_3210);
    drain(20);
    chk("zero_strb_writes", 64'(hs_cyc_q.size()), 64'(2));
    chk("zero_strb_gap", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 64'(2));

    // Backpressure: outputs held while READY is low.
    bus.CFG_READY = 1'b0;
    hs_cyc_q.delete();
    beat(32'h3000_0000, 8'hFF, 64'h0A0B_0C0D_0E0F_1011);
    repeat (6) tick();
    chk("bp_valid", 64'(bus.CFG_VALID), 64'(1));
    chk("bp_addr", 64'(bus.CFG_ADDR), 64'(32'h3000_0000));
    bus.CFG_READY = 1'b1;
    drain(20);
    chk("bp_writes", 64'(hs_cyc_q.size()), 64'(2));

    // Overflow: six back-to-back beats with READY low; one sits in hold, four in the FIFO.
    bus.CFG_READY = 1'b0;
    hs_cyc_q.delete();
    for (int i = 0; i < 6; i++) begin
      beat(32'h4000_0000 + 32'(i * 8), 8'hFF, {32'(i), 32'hC0DE_0000 + 32'(i)});
    end
    chk("ovf_set", 64'(bus.OVERFLOW), 64'(1));
    chk("ovf_full", 64'(bus.FULL), 64'(1));
    bus.CFG_READY = 1'b1;
    drain(40);
    chk("ovf_retained_writes", 64'(hs_cyc_q.size()), 64'(10));
    chk("ovf_sticky", 64'(bus.OVERFLOW), 64'(1));
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    chk("ovf_cleared", 64'(bus.OVERFLOW), 64'(0));

    // Reset while sending the high word with three beats queued.
    bus.CFG_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h5000_0000 + 32'(i * 8), 8'hFF, {32'h5A5A_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)});
    end
    bus.CFG_READY = 1'b1;
    tick();
    bus.CFG_READY = 1'b0;
    chk("pre_rst_hi_word", 64'(bus.CFG_ADDR), 64'(32'h5000_0004));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", 64'(bus.CFG_VALID), 64'(0));
    chk("post_rst_full", 64'(bus.FULL), 64'(0));
    chk("post_rst_overflow", 64'(bus.OVERFLOW), 64'(0));
    bus.CFG_READY = 1'b1;
    hs_cyc_q.delete();
    n = cyc;
    beat(32'h6000_0008, 8'h3C, 64'h1357_9BDF_2468_ACE0);
    drain(20);
    chk("post_rst_writes", 64'(hs_cyc_q.size()), 64'(2));
    chk("post_rst_latency", 64'(hs_cyc_q[0]), 64'(n + 2));

    // Streaming: 16 full beats, upstream throttled by FULL, READY held high.
    hs_cyc_q.delete();
    sent  = 0;
    guard = 0;
    while (sent < 16 && guard < 200) begin
      if (!bus.FULL) begin
        bus.SIF_ADDR = 32'h7000_0000 + 32'(sent * 8);
        bus.SIF_STRB = 8'hFF;
        bus.SIF_DATA = {$urandom, $urandom};
        bus.SIF_WE   = 1'b1;
        sent++;
      end else begin
        bus.SIF_WE = 1'b0;
      end
      tick();
      guard++;
    end
    bus.SIF_WE = 1'b0;
    drain(100);
    chk("stream_writes", 64'(hs_cyc_q.size()), 64'(32));
    chk("stream_span", 64'(hs_cyc_q[31] - hs_cyc_q[0]), 64'(31));

    // Random traffic with random backpressure, strobes and overflow clears.
    for (int i = 0; i < 400; i++) begin
      bus.SIF_WE   = ($urandom_range(0, 99) < 45);
      bus.SIF_ADDR = $urandom;
      bus.SIF_DATA = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0:       bus.SIF_STRB = 8'h00;
        1:       bus.SIF_STRB = 8'hFF;
        2:       bus.SIF_STRB = 8'h0F;
        3:       bus.SIF_STRB = 8'hF0;
        4:       bus.SIF_STRB = 8'h03;
        5:       bus.SIF_STRB = 8'hC0;
        default: bus.SIF_STRB = 8'($urandom);
      endcase
      bus.CFG_READY = ($urandom_range(0, 99) < 70);
      bus.OVF_CLR   = ($urandom_range(0, 99) < 5);
      tick();
    end
    bus.SIF_WE    = 1'b0;
    bus.OVF_CLR   = 1'b0;
    bus.CFG_READY = 1'b1;
    drain(200);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
